// File: rtl/collision_scheduler.sv
// Sweeps one shared collision detector across NUM_OBS obstacle slots per frame and latches game_over.
// Optional COLL_SCHED_OVERRUN_EN adds a sticky overrun flag for frame ticks that arrive mid-scan.
//
// state | meaning
// IDLE  | waiting for frame_tick (ignored while game_over is set)
// SCAN  | obs_sel walks 0..NUM_OBS-1, one slot evaluated per clock
// DONE  | one-cycle scan_done pulse, results already published
module collision_scheduler #(
  parameter int NUM_OBS = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             game_restart,
  output logic [IDX_W-1:0] obs_sel,
  input  logic             obs_active,
  input  logic             coll_in,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_index,
  output logic             game_over
`ifdef COLL_SCHED_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_OBS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] obs_sel_q, obs_sel_d;
  logic             scan_busy_q, scan_busy_d;
  logic             scan_done_q, scan_done_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic             game_over_q, game_over_d;
  logic             acc_hit_q, acc_hit_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic             slot_hit;
`ifdef COLL_SCHED_OVERRUN_EN
  logic             overrun_q, overrun_d;
`endif

  assign slot_hit = obs_active & coll_in;

  always_comb begin
    state_d     = state_q;
    obs_sel_d   = obs_sel_q;
    scan_busy_d = scan_busy_q;
    scan_done_d = 1'b0;
    hit_d       = hit_q;
    hit_index_d = hit_index_q;
    game_over_d = game_over_q;
    acc_hit_d   = acc_hit_q;
    acc_idx_d   = acc_idx_q;
`ifdef COLL_SCHED_OVERRUN_EN
    overrun_d   = overrun_q;
`endif
    if (game_restart) begin
      state_d     = IDLE;
      scan_busy_d = 1'b0;
      hit_d       = 1'b0;
      hit_index_d = '0;
      game_over_d = 1'b0;
      acc_hit_d   = 1'b0;
      acc_idx_d   = '0;
`ifdef COLL_SCHED_OVERRUN_EN
      overrun_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick && !game_over_q) begin
            state_d     = SCAN;
            obs_sel_d   = '0;
            scan_busy_d = 1'b1;
            acc_hit_d   = 1'b0;
            acc_idx_d   = '0;
          end
        end
        SCAN: begin
          if (slot_hit && !acc_hit_q) begin
            acc_hit_d = 1'b1;
            acc_idx_d = obs_sel_q;
          end
          // The last slot's result is folded in combinationally so it lands with scan_done.
          if (obs_sel_q == LAST_SLOT) begin
            state_d     = DONE;
            scan_busy_d = 1'b0;
            scan_done_d = 1'b1;
            hit_d       = acc_hit_d;
            hit_index_d = acc_idx_d;
            if (acc_hit_d) game_over_d = 1'b1;
          end else begin
            obs_sel_d = obs_sel_q + 1'b1;
          end
`ifdef COLL_SCHED_OVERRUN_EN
          if (frame_tick) overrun_d = 1'b1;
`endif
        end
        DONE: begin
          state_d = IDLE;
`ifdef COLL_SCHED_OVERRUN_EN
          if (frame_tick) overrun_d = 1'b1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      obs_sel_q   <= '0;
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      game_over_q <= 1'b0;
      acc_hit_q   <= 1'b0;
      acc_idx_q   <= '0;
`ifdef COLL_SCHED_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      obs_sel_q   <= obs_sel_d;
      scan_busy_q <= scan_busy_d;
      scan_done_q <= scan_done_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
      game_over_q <= game_over_d;
      acc_hit_q   <= acc_hit_d;
      acc_idx_q   <= acc_idx_d;
`ifdef COLL_SCHED_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign obs_sel   = obs_sel_q;
  assign scan_busy = scan_busy_q;
  assign scan_done = scan_done_q;
  assign hit       = hit_q;
  assign hit_index = hit_index_q;
  assign game_over = game_over_q;
`ifdef COLL_SCHED_OVERRUN_EN
  assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: vector table of slot masks, scan_done scoreboard, restart/reset corner sequences.
module tb_collision_scheduler;

  localparam int N = 4;

  logic       clk, rst_n, frame_tick, game_restart;
  logic [1:0] obs_sel, hit_index;
  logic       obs_active, coll_in, scan_busy, scan_done, hit, game_over;
`ifdef COLL_SCHED_OVERRUN_EN
  logic       overrun;
`endif

  logic [N-1:0] act_mask, coll_mask;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       hit;
    logic [1:0] idx;
    logic       go;
  } exp_t;

  typedef struct {
    logic [N-1:0] act;
    logic [N-1:0] coll;
    logic         ehit;
    logic [1:0]   eidx;
    logic         ego;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  collision_scheduler #(.NUM_OBS(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_restart(game_restart),
    .obs_sel(obs_sel), .obs_active(obs_active), .coll_in(coll_in),
    .scan_busy(scan_busy), .scan_done(scan_done), .hit(hit), .hit_index(hit_index),
    .game_over(game_over)
`ifdef COLL_SCHED_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Obstacle bank and detector model: same-cycle response to obs_sel.
  always_comb begin
    obs_active = act_mask[obs_sel];
    coll_in    = coll_mask[obs_sel];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && scan_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_scan_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_hit", {31'd0, hit}, {31'd0, e.hit});
        check("sb_hit_index", {30'd0, hit_index}, {30'd0, e.idx});
        check("sb_game_over", {31'd0, game_over}, {31'd0, e.go});
      end
    end
  end

  task automatic restart();
    @(negedge clk);
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    check("rst_game_over", {31'd0, game_over}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_hit_index", {30'd0, hit_index}, 32'd0);
    check("rst_scan_busy", {31'd0, scan_busy}, 32'd0);
`ifdef COLL_SCHED_OVERRUN_EN
    check("rst_overrun", {31'd0, overrun}, 32'd0);
`endif
  endtask

  task automatic run_scan(input logic [N-1:0] act, input logic [N-1:0] coll,
                          input logic ehit, input logic [1:0] eidx, input logic ego,
                          input logic extra_tick);
    exp_t e;
    act_mask  = act;
    coll_mask = coll;
    @(negedge clk);
    frame_tick = 1'b1;
    e.hit = ehit; e.idx = eidx; e.go = ego;
    sb_q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("scan_obs_sel", {30'd0, obs_sel}, k);
      check("scan_busy_hi", {31'd0, scan_busy}, 32'd1);
      check("scan_done_lo", {31'd0, scan_done}, 32'd0);
      frame_tick = (extra_tick && k == 1);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check("done_pulse", {31'd0, scan_done}, 32'd1);
    check("done_busy_lo", {31'd0, scan_busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, scan_done}, 32'd0);
    check("hit_holds", {31'd0, hit}, {31'd0, ehit});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            act      coll     hit   idx    go
    vecs[0] = '{4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{4'b1111, 4'b1010, 1'b1, 2'd1, 1'b1};
    vecs[2] = '{4'b1011, 4'b0100, 1'b0, 2'd0, 1'b0};
    vecs[3] = '{4'b1111, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[4] = '{4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[5] = '{4'b0111, 4'b1000, 1'b0, 2'd0, 1'b0};
    vecs[6] = '{4'b1110, 4'b1111, 1'b1, 2'd1, 1'b1};

    rst_n = 1'b0; frame_tick = 1'b0; game_restart = 1'b0;
    act_mask = '0; coll_mask = '0;
    repeat (2) @(negedge clk);
    check("reset_obs_sel", {30'd0, obs_sel}, 32'd0);
    check("reset_scan_busy", {31'd0, scan_busy}, 32'd0);
    check("reset_scan_done", {31'd0, scan_done}, 32'd0);
    check("reset_hit", {31'd0, hit}, 32'd0);
    check("reset_hit_index", {30'd0, hit_index}, 32'd0);
    check("reset_game_over", {31'd0, game_over}, 32'd0);
`ifdef COLL_SCHED_OVERRUN_EN
    check("reset_overrun", {31'd0, overrun}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (7) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      restart();
      run_scan(vecs[i].act, vecs[i].coll, vecs[i].ehit, vecs[i].eidx, vecs[i].ego, 1'b0);
    end

    // game_over is set from the last vector: further ticks must not start a scan.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("go_tick_ignored_busy", {31'd0, scan_busy}, 32'd0);
    check("go_sticky", {31'd0, game_over}, 32'd1);
    check("go_obs_sel_frozen", {30'd0, obs_sel}, 32'd3);
    repeat (6) @(negedge clk);
    check("go_still_idle", {31'd0, scan_busy}, 32'd0);

    // Restart and tick in the same cycle: restart wins, no scan.
    @(negedge clk);
    game_restart = 1'b1;
    frame_tick   = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    frame_tick   = 1'b0;
    check("rt_same_game_over", {31'd0, game_over}, 32'd0);
    check("rt_same_busy", {31'd0, scan_busy}, 32'd0);
    @(negedge clk);
    check("rt_same_no_scan", {31'd0, scan_busy}, 32'd0);
    run_scan(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Restart mid-scan at obs_sel=2: aborted, no scan_done.
    act_mask = 4'b1111; coll_mask = 4'b0100;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_obs_sel", {30'd0, obs_sel}, 32'd2);
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    check("abort_busy", {31'd0, scan_busy}, 32'd0);
    check("abort_game_over", {31'd0, game_over}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      check("abort_no_done", {31'd0, scan_done}, 32'd0);
      @(negedge clk);
    end
    run_scan(4'b1111, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);

    // Second tick during a scan is ignored; flags overrun when enabled.
    restart();
    run_scan(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
`ifdef COLL_SCHED_OVERRUN_EN
    check("overrun_set", {31'd0, overrun}, 32'd1);
    repeat (2) @(negedge clk);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    restart();
`endif

    // Asynchronous reset between clock edges mid-scan.
    restart();
    act_mask = 4'b1111; coll_mask = 4'b0000;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_obs_sel", {30'd0, obs_sel}, 32'd0);
    check("async_busy", {31'd0, scan_busy}, 32'd0);
    check("async_done", {31'd0, scan_done}, 32'd0);
    check("async_hit", {31'd0, hit}, 32'd0);
    check("async_game_over", {31'd0, game_over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {31'd0, scan_busy}, 32'd0);
    run_scan(4'b1111, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes one shared combinational collision detector across NUM_OBS obstacle slots, one slot per clock.
- Sits between the frame timing logic, the obstacle bank mux and the shared detector.
- On each frame_tick it sweeps every slot, records the lowest colliding active slot, reports a per-frame result and latches game_over until restart.

Parameters:
- NUM_OBS, 4: number of obstacle slots scanned per frame; legal range 2..16.
- IDX_W, 2: width of slot index; must satisfy 2**IDX_W >= NUM_OBS.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse, once per frame (vsync); starts a scan.
- game_restart  input  1  one-cycle pulse; clears game_over and aborts any scan.
- obs_sel  output  IDX_W  slot index driving the obstacle bank mux, and through it the shared detector.
- obs_active  input  1  valid bit of the slot addressed by obs_sel; combinational from the bank.
- coll_in  input  1  shared detector result for the slot on obs_sel; combinational, same cycle.
- scan_busy  output  1  high while a scan is in progress.
- scan_done  output  1  one-cycle pulse when a scan completes.
- hit  output  1  a collision occurred in the last completed scan.
- hit_index  output  IDX_W  lowest colliding active slot of the last completed scan.
- game_over  output  1  sticky collision flag.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; obs_sel=0, scan_busy=0, scan_done=0, hit=0, hit_index=0, game_over=0; internal accumulators cleared.
- All outputs are registered.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on frame_tick=1, game_over=0 and game_restart=0:
  - obs_sel<=0, scan_busy<=1, scan accumulators (acc_hit, acc_idx) cleared.
- SCAN, each cycle:
  - Slot k = obs_sel is evaluated in the cycle obs_sel=k. The slot collides if obs_active & coll_in.
  - On the first colliding slot of the scan: acc_hit<=1, acc_idx<=obs_sel. Later collisions do not change acc_idx.
  - If obs_sel==NUM_OBS-1: go to DONE, scan_busy<=0. Otherwise obs_sel<=obs_sel+1.
  - obs_sel never exceeds NUM_OBS-1. It holds its last value in IDLE and DONE.
- DONE (one cycle), then IDLE:
  - scan_done=1; hit<=acc_hit; hit_index<=acc_idx (0 if no hit).
  - If acc_hit=1, game_over<=1.
- Latency: frame_tick in cycle t -> obs_sel=0 at t+1 -> scan_done at t+NUM_OBS+1. hit, hit_index and game_over are valid in that same cycle.
- hit and hit_index hold until the next scan_done.
- frame_tick while in SCAN or DONE: ignored; the scan is not restarted.
- frame_tick while game_over=1: ignored; no scans run, so outputs freeze.
- game_restart, any state (highest priority):
  - next state IDLE; game_over<=0, hit<=0, hit_index<=0, scan_busy<=0, accumulators cleared.
  - No scan_done is generated for an aborted scan.
  - A frame_tick in the same cycle is dropped.
- Inactive slots (obs_active=0) never count, whatever coll_in is.
- The combinational path obs_sel -> bank mux -> detector -> coll_in must close in one clk period; no extra settle cycle is inserted.

Optional Feature:
- Macro COLL_SCHED_OVERRUN_EN.
- Defined:
  - Adds output overrun (1 bit, reset 0).
  - Set sticky when frame_tick arrives while in SCAN or DONE.
  - Cleared only by rst_n or game_restart.
  - Scan behaviour is otherwise unchanged.
- Undefined: no overrun port or logic; such ticks are silently ignored.

Test Plan:
- Basic scan, no hit: NUM_OBS=4, all obs_active=1, coll_in=0; frame_tick at cycle 10 -> obs_sel 0,1,2,3 in cycles 11-14; scan_done at 15; hit=0, hit_index=0, game_over=0.
- Multiple hits: coll_in=1 and active for slots 1 and 3 -> scan_done with hit=1, hit_index=1, game_over=1; a later frame_tick is ignored (scan_busy stays 0).
- Inactive slot: slot 2 has coll_in=1 but obs_active=0, all other slots coll_in=0 -> hit=0, game_over=0.
- Restart mid-scan: game_over=0, frame_tick, then game_restart while obs_sel=2 -> next cycle IDLE, scan_busy=0, no scan_done pulse. A frame_tick 3 cycles later runs a full scan from slot 0.
- Restart and tick in the same cycle: game_over=1 -> game_over=0 next cycle, no scan starts. A following frame_tick scans normally.
- Asynchronous reset: assert rst_n=0 mid-scan between clock edges -> all outputs 0 immediately. With COLL_SCHED_OVERRUN_EN, a second frame_tick during a scan -> overrun=1 until game_restart.
